// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the fetch sequencer.
// Optional interrupt support is enabled with the PC_SEQ_IRQ_EN macro.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        FETCH = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_INIT  = 3'd1,
        SEL_IRQ   = 3'd2,
        SEL_ERET  = 3'd3,
        SEL_REDIR = 3'd4,
        SEL_SEQ   = 3'd5
    } pc_sel_t;

    localparam logic [15:0] RESET_VEC_DEFAULT = 16'h0000;
    localparam logic [15:0] IRQ_VEC_DEFAULT   = 16'h0004;

endpackage

// File: rtl/pc_next_mux.sv
// Priority select for the next PC value and the kill flag of the returning fetch.
// Interrupt/return sources exist only when PC_SEQ_IRQ_EN is defined.
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter int unsigned         ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]   RESET_VEC = RESET_VEC_DEFAULT,
    parameter logic [ADDR_W-1:0]   IRQ_VEC   = IRQ_VEC_DEFAULT
) (
    input  logic              load_init,
    input  logic              ack,
    input  logic              halting,
    input  logic              idle_redir,
    input  logic              br_taken,
    input  logic              redir_pend,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] redir_addr,
    input  logic [ADDR_W-1:0] pc_cur,
`ifdef PC_SEQ_IRQ_EN
    input  logic              irq_hit,
    input  logic              eret_hit,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] pc_ret,
`endif
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_en,
    output logic              fetch_kill
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    pc_sel_t           sel;
    pc_sel_t           ret_sel;
    logic [ADDR_W-1:0] ret_val;
    logic [ADDR_W-1:0] redir_val;

    // Resolve the source priority; ret_sel is the choice an interrupt would preempt
    always_comb begin
        sel        = SEL_HOLD;
        ret_sel    = SEL_SEQ;
        fetch_kill = 1'b0;
        redir_val  = br_taken ? br_target : redir_addr;
`ifdef PC_SEQ_IRQ_EN
        if (eret_hit) begin
            ret_sel = SEL_ERET;
        end else if (br_taken || redir_pend) begin
            ret_sel = SEL_REDIR;
        end
`else
        if (br_taken || redir_pend) begin
            ret_sel = SEL_REDIR;
        end
`endif
        case (ret_sel)
`ifdef PC_SEQ_IRQ_EN
            SEL_ERET:  ret_val = epc;
`endif
            SEL_REDIR: ret_val = redir_val;
            default:   ret_val = pc_cur + ONE;
        endcase

        if (load_init) begin
            sel = SEL_INIT;
        end else if (ack) begin
            if (halting) begin
                fetch_kill = 1'b1;
            end else begin
                fetch_kill = (ret_sel != SEL_SEQ);
`ifdef PC_SEQ_IRQ_EN
                sel = irq_hit ? SEL_IRQ : ret_sel;
`else
                sel = ret_sel;
`endif
            end
        end else if (idle_redir) begin
            sel = ret_sel;
        end

        case (sel)
            SEL_INIT:  pc_next = RESET_VEC;
            SEL_IRQ:   pc_next = IRQ_VEC;
            SEL_ERET,
            SEL_REDIR,
            SEL_SEQ:   pc_next = ret_val;
            default:   pc_next = '0;
        endcase
        pc_en = (sel != SEL_HOLD);
    end

`ifdef PC_SEQ_IRQ_EN
    assign pc_ret = ret_val;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller: sequences the PC register and the one-at-a-time
// instruction fetch handshake, with halt, stall and late redirects.
// Interrupt entry/return (irq, eret, irq_ack, epc) exists only when
// PC_SEQ_IRQ_EN is defined.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned         ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]   RESET_VEC = RESET_VEC_DEFAULT,
    parameter logic [ADDR_W-1:0]   IRQ_VEC   = IRQ_VEC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              stall,
    input  logic              halt,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] pc_cur,
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_en,
    output logic              imem_req,
    input  logic              imem_ack,
    output logic              fetch_kill,
    output logic              busy,
`ifdef PC_SEQ_IRQ_EN
    input  logic              irq,
    input  logic              eret,
    output logic              irq_ack,
    output logic [ADDR_W-1:0] epc,
`endif
    output logic              unused_never
);

    state_t            state;
    logic              outstanding;
    logic              redir_pend;
    logic              halt_pend;
    logic [ADDR_W-1:0] redir_addr;
    logic              in_fetch;
    logic              ack_v;
    logic              halting;
    logic              redir_req;
    logic              idle_redir;
`ifdef PC_SEQ_IRQ_EN
    logic              eret_pend;
    logic              ie;
    logic [ADDR_W-1:0] pc_ret;
    logic              eret_taken;
`endif

    assign unused_never = 1'b0;

    // Handshake decode. A request raised this cycle counts as in flight, so a
    // redirect in that cycle is latched rather than moving the PC under it.
    always_comb begin
        in_fetch   = (state == FETCH);
        imem_req   = in_fetch && (outstanding || !stall);
        ack_v      = imem_req && imem_ack;
        halting    = ack_v && (halt || halt_pend);
`ifdef PC_SEQ_IRQ_EN
        redir_req  = br_taken || eret;
        irq_ack    = ack_v && !halting && irq && ie;
        eret_taken = (ack_v && !halting && !irq_ack && (eret || eret_pend))
                   || (in_fetch && !imem_req && eret);
`else
        redir_req  = br_taken;
`endif
        idle_redir = in_fetch && !imem_req && redir_req;
    end

    pc_next_mux #(
        .ADDR_W    (ADDR_W),
        .RESET_VEC (RESET_VEC),
        .IRQ_VEC   (IRQ_VEC)
    ) u_mux (
        .load_init  (state == INIT),
        .ack        (ack_v),
        .halting    (halting),
        .idle_redir (idle_redir),
        .br_taken   (br_taken),
        .redir_pend (redir_pend),
        .br_target  (br_target),
        .redir_addr (redir_addr),
        .pc_cur     (pc_cur),
`ifdef PC_SEQ_IRQ_EN
        .irq_hit    (irq && ie),
        .eret_hit   (eret || eret_pend),
        .epc        (epc),
        .pc_ret     (pc_ret),
`endif
        .pc_next    (pc_next),
        .pc_en      (pc_en),
        .fetch_kill (fetch_kill)
    );

    // Control FSM with the outstanding, redirect, halt and interrupt bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            outstanding <= 1'b0;
            redir_pend  <= 1'b0;
            halt_pend   <= 1'b0;
            redir_addr  <= '0;
`ifdef PC_SEQ_IRQ_EN
            eret_pend   <= 1'b0;
            ie          <= 1'b1;
            epc         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= INIT;
                    end
                end
                INIT: begin
                    state <= FETCH;
                    busy  <= 1'b1;
                end
                FETCH: begin
                    if (halting) begin
                        state       <= HALT;
                        busy        <= 1'b0;
                        outstanding <= 1'b0;
                        halt_pend   <= 1'b0;
                        redir_pend  <= 1'b0;
`ifdef PC_SEQ_IRQ_EN
                        eret_pend   <= 1'b0;
`endif
                    end else begin
                        outstanding <= imem_req && !imem_ack;
                        if (halt) begin
                            halt_pend <= 1'b1;
                        end
                        if (ack_v) begin
                            redir_pend <= 1'b0;
                        end else if (imem_req && br_taken) begin
                            redir_pend <= 1'b1;
                            redir_addr <= br_target;
                        end
`ifdef PC_SEQ_IRQ_EN
                        if (ack_v) begin
                            eret_pend <= 1'b0;
                        end else if (imem_req && eret) begin
                            eret_pend <= 1'b1;
                        end
                        if (irq_ack) begin
                            epc <= pc_ret;
                            ie  <= 1'b0;
                        end else if (eret_taken) begin
                            ie  <= 1'b1;
                        end
`endif
                    end
                end
                HALT: begin
                    if (run) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; the interrupt scenario
// is included when PC_SEQ_IRQ_EN is defined.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic        stall;
    logic        halt;
    logic        br_taken;
    logic [15:0] br_target;
    logic [15:0] pc_cur;
    logic [15:0] pc_next;
    logic        pc_en;
    logic        imem_req;
    logic        imem_ack;
    logic        fetch_kill;
    logic        busy;
    logic        unused_never;
`ifdef PC_SEQ_IRQ_EN
    logic        irq;
    logic        eret;
    logic        irq_ack;
    logic [15:0] epc;
`endif

    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [15:0] pc_reg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // PC register model fed by the sequencer, with a bench preload port
    always @(posedge clk) begin
        if (pc_load) pc_reg <= pc_load_val;
        else if (pc_en) pc_reg <= pc_next;
    end
    assign pc_cur = pc_reg;

    pc_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .run          (run),
        .stall        (stall),
        .halt         (halt),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .pc_cur       (pc_cur),
        .pc_next      (pc_next),
        .pc_en        (pc_en),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .fetch_kill   (fetch_kill),
        .busy         (busy),
`ifdef PC_SEQ_IRQ_EN
        .irq          (irq),
        .eret         (eret),
        .irq_ack      (irq_ack),
        .epc          (epc),
`endif
        .unused_never (unused_never)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; run = 1'b0; stall = 1'b0; halt = 1'b0;
        br_taken = 1'b0; br_target = 16'h0000; imem_ack = 1'b0;
        pc_load = 1'b1; pc_load_val = 16'h0000;
`ifdef PC_SEQ_IRQ_EN
        irq = 1'b0; eret = 1'b0;
`endif
        tick(); tick();
        reset_n = 1'b1; pc_load = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_imem_req: got %b want 0", imem_req); end
        n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pc_en: got %b want 0", pc_en); end
        n_checks++; if (pc_next !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_pc_next: got %h want 0000", pc_next); end
        n_checks++; if (fetch_kill !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_kill: got %b want 0", fetch_kill); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
`ifdef PC_SEQ_IRQ_EN
        n_checks++; if (irq_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq_ack: got %b want 0", irq_ack); end
        n_checks++; if (epc !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_epc: got %h want 0000", epc); end
`endif
        tick();
    endtask

    task automatic test_sequential();
        run = 1'b1;
        tick();
        run = 1'b0;
        @(negedge clk);
        n_checks++; if (pc_en !== 1'b1) begin n_fail++; $display("[TB] FAIL init_pc_en: got %b want 1", pc_en); end
        n_checks++; if (pc_next !== 16'h0000) begin n_fail++; $display("[TB] FAIL init_pc_next: got %h want 0000", pc_next); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL init_imem_req: got %b want 0", imem_req); end
        tick();
        for (int i = 1; i <= 3; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            n_checks++; if (imem_req !== 1'b1 || busy !== 1'b1 || pc_en !== 1'b0) begin n_fail++; $display("[TB] FAIL seq_wait_%0d: req=%b busy=%b pc_en=%b want 1 1 0", i, imem_req, busy, pc_en); end
            tick();
            imem_ack = 1'b1;
            @(negedge clk);
            n_checks++; if (pc_next !== 16'(i) || pc_en !== 1'b1) begin n_fail++; $display("[TB] FAIL seq_ack_%0d: pc_next=%h pc_en=%b want %h 1", i, pc_next, pc_en, 16'(i)); end
            n_checks++; if (fetch_kill !== 1'b0 || imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL seq_ack_flags_%0d: kill=%b req=%b want 0 1", i, fetch_kill, imem_req); end
            tick();
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_wrap();
        stall = 1'b1; pc_load = 1'b1; pc_load_val = 16'hFFFF;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0 || pc_en !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_stall: req=%b pc_en=%b want 0 0", imem_req, pc_en); end
        tick();
        pc_load = 1'b0; stall = 1'b0; imem_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (pc_next !== 16'h0000 || pc_en !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_pc_next: pc_next=%h pc_en=%b want 0000 1", pc_next, pc_en); end
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic test_redirect();
        tick();
        br_taken = 1'b1; br_target = 16'h0040;
        @(negedge clk);
        n_checks++; if (pc_en !== 1'b0 || imem_req !== 1'b1 || fetch_kill !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_latch: pc_en=%b req=%b kill=%b want 0 1 0", pc_en, imem_req, fetch_kill); end
        tick();
        br_taken = 1'b0; br_target = 16'h1234; stall = 1'b1;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_holds_req: got %b want 1", imem_req); end
        tick();
        stall = 1'b0;
        tick();
        imem_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (pc_next !== 16'h0040 || pc_en !== 1'b1 || fetch_kill !== 1'b1) begin n_fail++; $display("[TB] FAIL redir_apply: pc_next=%h pc_en=%b kill=%b want 0040 1 1", pc_next, pc_en, fetch_kill); end
        tick();
        imem_ack = 1'b0; stall = 1'b1;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0 || pc_en !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_idle: req=%b pc_en=%b want 0 0", imem_req, pc_en); end
        tick();
        br_taken = 1'b1; br_target = 16'h0080;
        @(negedge clk);
        n_checks++; if (pc_cur !== 16'h0040) begin n_fail++; $display("[TB] FAIL stall_pc_held: got %h want 0040", pc_cur); end
        n_checks++; if (pc_next !== 16'h0080 || pc_en !== 1'b1 || fetch_kill !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_idle: pc_next=%h pc_en=%b kill=%b want 0080 1 0", pc_next, pc_en, fetch_kill); end
        tick();
        stall = 1'b0; br_target = 16'h00A0; imem_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (pc_next !== 16'h00A0 || fetch_kill !== 1'b1) begin n_fail++; $display("[TB] FAIL redir_with_ack: pc_next=%h kill=%b want 00a0 1", pc_next, fetch_kill); end
        tick();
        br_taken = 1'b0; imem_ack = 1'b0;
    endtask

    task automatic test_halt();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();
        imem_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (pc_en !== 1'b0 || fetch_kill !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_ack: pc_en=%b kill=%b want 0 1", pc_en, fetch_kill); end
        tick();
        imem_ack = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0 || busy !== 1'b0 || pc_cur !== 16'h00A0) begin n_fail++; $display("[TB] FAIL halt_state: req=%b busy=%b pc=%h want 0 0 00a0", imem_req, busy, pc_cur); end
        tick();
        run = 1'b1;
        tick();
        run = 1'b0; imem_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1 || busy !== 1'b1 || pc_next !== 16'h00A1 || fetch_kill !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_resume: req=%b busy=%b pc_next=%h kill=%b want 1 1 00a1 0", imem_req, busy, pc_next, fetch_kill); end
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic test_reset_outstanding();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; imem_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0 || pc_en !== 1'b0 || busy !== 1'b0 || fetch_kill !== 1'b0 || pc_next !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_mid_fetch: req=%b pc_en=%b busy=%b kill=%b pc_next=%h want all 0", imem_req, pc_en, busy, fetch_kill, pc_next); end
        tick();
        imem_ack = 1'b0; run = 1'b1; halt = 1'b1;
        tick();
        run = 1'b0;
        @(negedge clk);
        n_checks++; if (pc_en !== 1'b1 || pc_next !== 16'h0000) begin n_fail++; $display("[TB] FAIL run_beats_halt: pc_en=%b pc_next=%h want 1 0000", pc_en, pc_next); end
        tick();
        halt = 1'b0; imem_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || pc_next !== 16'h0001 || fetch_kill !== 1'b0) begin n_fail++; $display("[TB] FAIL restart_fetch: busy=%b pc_next=%h kill=%b want 1 0001 0", busy, pc_next, fetch_kill); end
        tick();
        imem_ack = 1'b0;
    endtask

`ifdef PC_SEQ_IRQ_EN
    task automatic test_irq();
        stall = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0010;
        tick();
        pc_load = 1'b0; stall = 1'b0; irq = 1'b1; imem_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (pc_next !== 16'h0004 || irq_ack !== 1'b1 || fetch_kill !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_take: pc_next=%h irq_ack=%b kill=%b want 0004 1 0", pc_next, irq_ack, fetch_kill); end
        tick();
        @(negedge clk);
        n_checks++; if (epc !== 16'h0011) begin n_fail++; $display("[TB] FAIL irq_epc: got %h want 0011", epc); end
        n_checks++; if (irq_ack !== 1'b0 || pc_next !== 16'h0005) begin n_fail++; $display("[TB] FAIL irq_masked: irq_ack=%b pc_next=%h want 0 0005", irq_ack, pc_next); end
        tick();
        irq = 1'b0; eret = 1'b1;
        @(negedge clk);
        n_checks++; if (pc_next !== 16'h0011 || pc_en !== 1'b1) begin n_fail++; $display("[TB] FAIL eret_return: pc_next=%h pc_en=%b want 0011 1", pc_next, pc_en); end
        tick();
        eret = 1'b0; irq = 1'b1;
        @(negedge clk);
        n_checks++; if (irq_ack !== 1'b1 || pc_next !== 16'h0004) begin n_fail++; $display("[TB] FAIL irq_reenabled: irq_ack=%b pc_next=%h want 1 0004", irq_ack, pc_next); end
        tick();
        irq = 1'b0; imem_ack = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_redirect();
        test_halt();
        test_reset_outstanding();
`ifdef PC_SEQ_IRQ_EN
        test_irq();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch controller that sequences the 16-bit `program_counter` register and the instruction-memory request handshake. It computes the next PC, from sequential increment, branch/jump redirect or interrupt vector, and drives `pc_in`/`enable` of the PC register. It also issues one instruction fetch at a time, and handles halt, stall and redirect-while-outstanding. It sits between decode/execute (redirect, halt, stall sources) and the PC register plus instruction memory.

## Interface
Parameters:
- `ADDR_W`, 16, PC/address width
- `RESET_VEC`, 16'h0000, PC loaded on leaving IDLE after reset
- `IRQ_VEC`, 16'h0004, interrupt handler address (used only with `PC_SEQ_IRQ_EN`)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `run`  in  1  start/resume fetching from IDLE or HALT
- `stall`  in  1  hazard stall; blocks issue of a new fetch
- `halt`  in  1  HALT decoded; stop after current fetch
- `br_taken`  in  1  redirect request (branch/jump)
- `br_target`  in  ADDR_W  redirect address
- `pc_cur`  in  ADDR_W  current PC (PC register output)
- `pc_next`  out  ADDR_W  next PC value (to PC register `pc_in`)
- `pc_en`  out  1  PC register load enable
- `imem_req`  out  1  fetch request; address is `pc_cur`
- `imem_ack`  in  1  fetch complete (one-cycle pulse)
- `fetch_kill`  out  1  instruction returned with this ack must be discarded
- `busy`  out  1  state is FETCH
- `irq`, `eret`  in  1  level interrupt request / return-from-interrupt (macro only)
- `irq_ack`  out  1, `epc`  out  ADDR_W  interrupt taken pulse / saved return PC (macro only)

## Operation
- States: IDLE, INIT, FETCH, HALT. Reset → IDLE.
- IDLE: `run` → INIT. INIT lasts one cycle: `pc_en`=1, `pc_next`=`RESET_VEC` → FETCH.
- FETCH handshake:
  - `imem_req` = `outstanding` | !`stall`.
  - `outstanding` sets when `imem_req`=1 without `imem_ack` and clears on ack.
  - Once raised, `imem_req` holds until `imem_ack`. `stall` never cancels an outstanding request.
- On ack, `pc_en`=1 (combinational from `imem_ack`). `pc_next` priority:
  1. IRQ: `IRQ_VEC`, when `irq` & `ie`.
  2. ERET: `epc`, when `eret` or a pending eret.
  3. Redirect: `br_target`, or latched `redir_addr`.
  4. Sequential: `pc_cur`+1, modulo 2^ADDR_W, so 16'hFFFF → 16'h0000.
- Redirect while outstanding and no ack:
  - latch `redir_pend`=1 and `redir_addr`=`br_target`; a later `br_taken` overwrites the latch.
  - On ack, apply the redirect, assert `fetch_kill`, clear `redir_pend`.
  - Redirect arriving in the same cycle as the ack is applied immediately, with `fetch_kill`=1.
- Redirect with no request outstanding: `pc_en`=1, `pc_next`=target that cycle, no kill.
- `halt` in FETCH sets `halt_pend`. The next ack with `halt_pend` or `halt`: `pc_en`=0, `fetch_kill`=1 → HALT. `halt` is ignored outside FETCH.
- HALT: `imem_req`=0. `run` → FETCH, resuming at the held `pc_cur`.
- IDLE with `run` and `halt` both high: `run` wins.

## Timing
- Reset values: `imem_req`=0, `pc_en`=0, `pc_next`=0, `fetch_kill`=0, `busy`=0, `irq_ack`=0, `epc`=0, `ie`=1; all pending flags 0.
- `reset_n` low in any state (including with a request outstanding) → IDLE at the next edge. Outputs are 0 from the following cycle; memory must tolerate the dropped request.
- Latency:
  - `run` at cycle N → INIT at N+1 → first `imem_req` at N+2.
  - Ack at cycle M → PC register updates at M+1, and the new address is requested at M+1 (back-to-back, no bubble unless `stall`).
- `fetch_kill` and `irq_ack` are single-cycle, coincident with the ack.

## Configuration
- `PC_SEQ_IRQ_EN` defined:
  - `irq`/`eret`/`irq_ack`/`epc` are present; `ie` register is implemented.
  - IRQ taken on ack when `irq`&`ie`: `epc` ← the PC that would otherwise have loaded, `ie` ← 0, `irq_ack`=1, `fetch_kill` unchanged.
  - ERET: loads `epc`, sets `ie` ← 1; it is latched like a redirect when outstanding.
- Undefined: those ports and the `ie`/`epc` logic are absent; priority list reduces to redirect > sequential.

## Structure
- Package `pc_seq_pkg`: state enum (IDLE, INIT, FETCH, HALT), `RESET_VEC`/`IRQ_VEC` defaults, next-PC select enum.
- Sub-module `pc_next_mux`: combinational priority select producing `pc_next` and `fetch_kill`. FSM, pending latches and handshake stay in `pc_sequencer`.

## Test plan
- Reset, `run`, ack every 2nd cycle: `pc_next` sequence 0,1,2,3; `imem_req` continuous; no kill.
- `pc_cur`=16'hFFFF, ack → `pc_next`=16'h0000.
- `br_taken`, `br_target`=16'h0040 while outstanding, ack 3 cycles later → `pc_next`=16'h0040, `fetch_kill`=1; then `stall`=1 with no request outstanding → `imem_req`=0, PC held.
- `halt` mid-fetch → kill on ack, HALT, `imem_req`=0; `run` resumes at held PC; `reset_n`=0 with request outstanding → IDLE, all outputs 0 next cycle.
- (`PC_SEQ_IRQ_EN`) `irq` with `pc_cur`=16'h0010 and ack → `pc_next`=16'h0004, `epc`=16'h0011, `irq_ack`=1; second `irq` ignored; `eret` → `pc_next`=16'h0011, `ie`=1.
